// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: holds mem_addr stable for MEM_LAT cycles, registers the word
// and offers it to the core over valid/ready. Optional FETCH_PERF_CNT_EN builds the fetch counter.
module inst_fetch_ctrl #(
  parameter int unsigned MEM_LAT   = 3,
  parameter int unsigned MEM_WORDS = 9,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic        range_err,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] MEM_BYTES  = 32'(MEM_WORDS * 4);
  localparam logic [3:0]  LAT_RELOAD = 4'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] mem_addr_q;
  logic [31:0] inst_out_q;
  logic [31:0] inst_pc_q;
  logic        inst_valid_q;
  logic        range_err_q;
  logic [3:0]  lat_cnt_q;

  logic [31:0] redir_aligned_d;
  logic        redir_oor_d;
  logic [31:0] redir_tgt_d;
  logic [31:0] pc_inc_d;
  logic [31:0] pc_next_d;
  logic [31:0] fetch_pc_d;

  // Redirect target sanitising and the sequential next PC (wraps at the populated depth).
  always_comb begin
    redir_aligned_d = redirect_pc & ~32'd3;
    redir_oor_d     = (redir_aligned_d >= MEM_BYTES);
    redir_tgt_d     = redir_oor_d ? RESET_PC : redir_aligned_d;
    pc_inc_d        = pc_q + 32'd4;
    pc_next_d       = (pc_inc_d == MEM_BYTES) ? 32'd0 : pc_inc_d;
    fetch_pc_d      = redirect_valid ? redir_tgt_d : pc_next_d;
  end

  // Fetch FSM; mem_addr only moves when (re)entering WAIT so the read window stays stable.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      mem_addr_q   <= RESET_PC;
      inst_out_q   <= 32'd0;
      inst_pc_q    <= 32'd0;
      inst_valid_q <= 1'b0;
      range_err_q  <= 1'b0;
      lat_cnt_q    <= 4'd0;
    end else begin
      if (redirect_valid && redir_oor_d) begin
        range_err_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (redirect_valid) begin
            pc_q <= redir_tgt_d;
            if (en) begin
              state_q    <= WAIT;
              mem_addr_q <= redir_tgt_d;
              lat_cnt_q  <= LAT_RELOAD;
            end
          end else if (en) begin
            state_q    <= WAIT;
            mem_addr_q <= pc_q;
            lat_cnt_q  <= LAT_RELOAD;
          end
        end
        WAIT: begin
          if (redirect_valid) begin
            // In-flight read is discarded; with en low the target is kept for re-enable.
            pc_q <= redir_tgt_d;
            if (en) begin
              mem_addr_q <= redir_tgt_d;
              lat_cnt_q  <= LAT_RELOAD;
            end else begin
              state_q <= IDLE;
            end
          end else if (!en) begin
            state_q <= IDLE;
          end else if (lat_cnt_q != 4'd0) begin
            lat_cnt_q <= lat_cnt_q - 4'd1;
          end else begin
            inst_out_q   <= mem_rdata;
            inst_pc_q    <= mem_addr_q;
            inst_valid_q <= 1'b1;
            state_q      <= HOLD;
          end
        end
        HOLD: begin
          if (inst_ready) begin
            inst_valid_q <= 1'b0;
            pc_q         <= fetch_pc_d;
            if (en) begin
              state_q    <= WAIT;
              mem_addr_q <= fetch_pc_d;
              lat_cnt_q  <= LAT_RELOAD;
            end else begin
              state_q <= IDLE;
            end
          end else if (redirect_valid) begin
            inst_valid_q <= 1'b0;
            pc_q         <= redir_tgt_d;
            mem_addr_q   <= redir_tgt_d;
            lat_cnt_q    <= LAT_RELOAD;
            state_q      <= WAIT;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_addr   = mem_addr_q;
  assign inst_out   = inst_out_q;
  assign inst_pc    = inst_pc_q;
  assign inst_valid = inst_valid_q;
  assign range_err  = range_err_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count_q;

  // Saturating count of accepted instructions.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count_q <= 32'd0;
    end else if (inst_valid_q && inst_ready && (fetch_count_q != 32'hFFFF_FFFF)) begin
      fetch_count_q <= fetch_count_q + 32'd1;
    end
  end

  assign fetch_count = fetch_count_q;
`else
  assign fetch_count = 32'd0;
`endif

endmodule

// File: doc/inst_fetch_ctrl.md
# inst_fetch_ctrl

Fetch sequencer between the core and the instruction memory. Owns the program counter, presents a stable word address to the memory, and waits a fixed number of cycles for the memory's combinational-plus-delay read path to settle. It then registers the instruction and hands it to the core with a valid/ready handshake. It also handles branch/jump redirects and wraps the PC over the populated memory depth.

## Interface
- MEM_LAT, 3: cycles mem_addr must be held stable before mem_rdata is sampled; legal range 1..15.
- MEM_WORDS, 9: populated instruction words; byte address space is 0..MEM_WORDS*4-1.
- RESET_PC, 0: PC value after reset and after an out-of-range redirect; word-aligned, < MEM_WORDS*4.
- clk  in  1  rising-edge clock.
- reset  in  1  reset, synchronous, active-high.
- en  in  1  fetch enable; level-sensitive.
- redirect_valid  in  1  load a new PC this cycle (taken branch/jump).
- redirect_pc  in  32  byte target address for a redirect.
- mem_addr  out  32  byte address to the instruction memory; registered.
- mem_rdata  in  32  instruction word returned by memory.
- inst_out  out  32  registered instruction to the core.
- inst_pc  out  32  byte address of inst_out.
- inst_valid  out  1  inst_out/inst_pc are valid.
- inst_ready  in  1  core accepts the instruction.
- range_err  out  1  sticky; set by an out-of-range redirect.
- fetch_count  out  32  accepted-instruction counter (see Configuration).

## Operation
- States: IDLE, WAIT, HOLD. Counter lat_cnt has width 4.
- Reset: state=IDLE, pc=RESET_PC, mem_addr=RESET_PC, inst_out=0, inst_pc=0, inst_valid=0, range_err=0, fetch_count=0, lat_cnt=0.
- IDLE with en=1: go to WAIT, mem_addr<=pc, lat_cnt<=MEM_LAT-1.
- WAIT with lat_cnt!=0: decrement.
- WAIT with lat_cnt==0: inst_out<=mem_rdata, inst_pc<=mem_addr, inst_valid<=1, go to HOLD.
- WAIT with en=0: abort to IDLE. pc is unchanged, so the same address is refetched on re-enable.
- HOLD: outputs are frozen until inst_valid&&inst_ready.
  - On handshake, pc_next = pc+4, or 0 if pc+4 == MEM_WORDS*4.
  - If en=1, go to WAIT with mem_addr<=pc_next and lat_cnt reloaded. Otherwise go to IDLE with pc<=pc_next.
  - inst_valid drops on the handshake edge unless reloaded. It is never reloaded directly from HOLD.
- Redirect has priority over the normal next-PC in every state.
  - target = {redirect_pc[31:2],2'b00}. Low bits are silently cleared.
  - If target >= MEM_WORDS*4, target=RESET_PC and range_err<=1 (sticky until reset).
  - In WAIT: restart WAIT at target with lat_cnt reloaded. The in-flight read is discarded.
  - In HOLD without handshake: inst_valid<=0, go to WAIT at target. The held instruction is dropped.
  - In HOLD with handshake on the same cycle: the instruction counts as accepted, and the next fetch uses target instead of pc_next.
  - In IDLE: pc<=target; go to WAIT only if en=1.
- mem_addr changes only on entry to WAIT, so it is stable for the full MEM_LAT window.

## Timing
- Latency from the edge entering WAIT to inst_valid=1 is MEM_LAT cycles. Example: MEM_LAT=3, WAIT entered at edge N, valid after edge N+3.
- With inst_ready held at 1, throughput is one instruction per MEM_LAT+1 cycles.
- From IDLE, en sampled 1 at edge N gives mem_addr valid after N and inst_valid after N+MEM_LAT.
- A redirect sampled at edge N puts target on mem_addr after N, and its instruction is valid after N+MEM_LAT.
- reset asserted mid-operation: all outputs take their reset values at that edge, and any held or in-flight instruction is lost.
- inst_valid is never deasserted without a handshake, except by redirect or reset.

## Configuration
- FETCH_PERF_CNT_EN defined: fetch_count increments by 1 on every inst_valid&&inst_ready edge and saturates at 32'hFFFFFFFF.
- FETCH_PERF_CNT_EN undefined: no counter logic is built and fetch_count is tied to 0.

## Test plan
- Reset, then en=1 and inst_ready=1 with MEM_LAT=3 and MEM_WORDS=9 → inst_pc sequence 0,4,…,32,0. inst_valid is high one cycle in every 4. inst_out matches the memory words.
- inst_ready=0 for 5 cycles in HOLD → inst_out, inst_pc and inst_valid stay constant, and mem_addr does not change.
- redirect_valid=1 with redirect_pc=0x9 during WAIT → mem_addr=0x8, and the valid instruction appears exactly 3 cycles later with inst_pc=8.
- Handshake and redirect_pc=0x4 on the same HOLD cycle → the instruction is accepted (fetch_count +1 when enabled), and the next inst_pc is 4.
- redirect_pc=0x40 → mem_addr=RESET_PC and range_err=1; range_err stays 1 until reset.
- reset pulsed during WAIT, then en dropped in WAIT → outputs return to reset values, and after re-enable the first inst_pc is 0.
